// File: rtl/uart_tx_fifo_drain_if.sv
// Handshake bundle between the FIFO read side and the UART transmitter.
// The master modport is the transmitter's view; slave is the FIFO/line side.
interface uart_tx_fifo_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;
  logic       cts;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  cts,
    output fifo_read,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output cts,
    input  fifo_read,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter fed from the read side of a FIFO: one byte fetched per frame, sent as
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits at CLKS_PER_BIT clocks/bit.
module uart_tx_fifo_drain #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  uart_tx_fifo_drain_if.master bus_io
);

  localparam int unsigned CntW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic HasParity = (PARITY != 0);
  localparam logic OddParity = (PARITY == 2);
  localparam logic StopLast  = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_q, stop_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;

  logic baud_wrap;
  assign baud_wrap = (baud_q == CntLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    case (state_q)
      StIdle: begin
        // Cts is only consulted here, so a mid-frame drop never aborts a frame
        if (!bus_io.fifo_empty && bus_io.cts) begin
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StLoad;
      end
      StLoad: begin
        shift_d  = bus_io.fifo_data;
        parity_d = (^bus_io.fifo_data) ^ OddParity;
        baud_d   = '0;
        state_d  = StStart;
      end
      StStart: begin
        if (baud_wrap) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StData: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = HasParity ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StParity: begin
        if (baud_wrap) begin
          baud_d  = '0;
          stop_d  = 1'b0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      StStop: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (stop_q == StopLast) begin
            stop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All outputs decode registered state only, keeping FifoRead and Tx glitch-free.
  always_comb begin
    bus_io.tx = 1'b1;
    case (state_q)
      StStart:  bus_io.tx = 1'b0;
      StData:   bus_io.tx = shift_q[bit_idx_q];
      StParity: bus_io.tx = parity_q;
      default:  bus_io.tx = 1'b1;
    endcase
    bus_io.fifo_read = (state_q == StRead);
    bus_io.busy      = (state_q != StIdle);
    bus_io.done      = (state_q == StStop) && baud_wrap && (stop_q == StopLast);
  end

endmodule
